pipe_multiplier: RTL and testbench

PIPE_MULTIPLIER -- requirements
Module: pipe_multiplier

---
 rtl/mult_pkg.sv | 14 +
 rtl/mult_stage.sv | 118 +++++++++++
 rtl/pipe_multiplier.sv | 145 ++++++++++++++
 tb/tb_pipe_multiplier.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared width defaults and latency helper for pipe_multiplier.
// Optional tag sideband is controlled by the PIPE_MULT_TAG_EN macro.
package mult_pkg;

    localparam int A_W_DEF   = 11;
    localparam int B_W_DEF   = 8;
    localparam int TAG_W_DEF = 4;

    // One input register stage plus one shift-add stage per multiplier bit.
    function automatic int latency(input int b_w);
        return b_w + 1;
    endfunction

endpackage

// File: rtl/mult_stage.sv
// mult_stage: one shift-add (or final shift-subtract) partial-product step.
// Tag carry registers exist only when PIPE_MULT_TAG_EN is defined.
module mult_stage
    import mult_pkg::*;
#(
    parameter int A_W = A_W_DEF,
    parameter int B_W = B_W_DEF,
    parameter int K   = 1
`ifdef PIPE_MULT_TAG_EN
    ,
    parameter int TAG_W = TAG_W_DEF
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ce,
    input  logic                       in_valid,
    input  logic                       in_mode,
    input  logic signed [A_W-1:0]      in_a,
    input  logic        [B_W-1:0]      in_b,
    input  logic signed [A_W+B_W-1:0]  in_acc,
    output logic                       out_valid,
    output logic                       out_mode,
    output logic signed [A_W-1:0]      out_a,
    output logic        [B_W-1:0]      out_b,
    output logic signed [A_W+B_W-1:0]  out_acc
`ifdef PIPE_MULT_TAG_EN
    ,
    input  logic        [TAG_W-1:0]    in_tag,
    output logic        [TAG_W-1:0]    out_tag
`endif
);

    localparam int P_W  = A_W + B_W;
    localparam bit LAST = (K == B_W);

    logic signed [P_W-1:0] term;
    logic signed [P_W-1:0] sum;

    logic                  valid_q, valid_d;
    logic                  mode_q,  mode_d;
    logic signed [A_W-1:0] a_q,     a_d;
    logic        [B_W-1:0] b_q,     b_d;
    logic signed [P_W-1:0] acc_q,   acc_d;
`ifdef PIPE_MULT_TAG_EN
    logic [TAG_W-1:0]      tag_q,   tag_d;
`endif

    // Partial product for bit K-1; the sign bit's weight is negative in signed mode.
    always_comb begin
        term = {{B_W{in_a[A_W-1]}}, in_a} << (K - 1);
        sum  = in_acc;
        if (in_b[K-1]) begin
            if (LAST && in_mode) begin
                sum = in_acc - term;
            end else begin
                sum = in_acc + term;
            end
        end
    end

    // Valid advances on every enabled edge; payload only loads for real samples.
    always_comb begin
        valid_d = valid_q;
        mode_d  = mode_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
`ifdef PIPE_MULT_TAG_EN
        tag_d   = tag_q;
`endif
        if (ce) begin
            valid_d = in_valid;
        end
        if (ce && in_valid) begin
            mode_d = in_mode;
            a_d    = in_a;
            b_d    = in_b;
            acc_d  = sum;
`ifdef PIPE_MULT_TAG_EN
            tag_d  = in_tag;
`endif
        end
    end

    // Stage registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            mode_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
`ifdef PIPE_MULT_TAG_EN
            tag_q   <= '0;
`endif
        end else begin
            valid_q <= valid_d;
            mode_q  <= mode_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
`ifdef PIPE_MULT_TAG_EN
            tag_q   <= tag_d;
`endif
        end
    end

    assign out_valid = valid_q;
    assign out_mode  = mode_q;
    assign out_a     = a_q;
    assign out_b     = b_q;
    assign out_acc   = acc_q;
`ifdef PIPE_MULT_TAG_EN
    assign out_tag   = tag_q;
`endif

endmodule

// File: rtl/pipe_multiplier.sv
// pipe_multiplier: fully pipelined exact signed x (signed|unsigned) multiplier.
// Define PIPE_MULT_TAG_EN to add the in_tag/out_tag sideband.
module pipe_multiplier
    import mult_pkg::*;
#(
    parameter int A_W   = A_W_DEF,
    parameter int B_W   = B_W_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ce,
    input  logic                       in_valid,
    input  logic signed [A_W-1:0]      in_a,
    input  logic        [B_W-1:0]      in_b,
    input  logic                       in_b_signed,
    output logic                       out_valid,
    output logic signed [A_W+B_W-1:0]  out_p
`ifdef PIPE_MULT_TAG_EN
    ,
    input  logic        [TAG_W-1:0]    in_tag,
    output logic        [TAG_W-1:0]    out_tag
`endif
);

    localparam int P_W = A_W + B_W;
    localparam int LAT = latency(B_W);

    if (A_W < 2 || A_W > 24) begin : g_bad_a_w
        $error("pipe_multiplier: A_W must be 2..24");
    end
    if (B_W < 2 || B_W > 16) begin : g_bad_b_w
        $error("pipe_multiplier: B_W must be 2..16");
    end
    if (TAG_W < 1) begin : g_bad_tag_w
        $error("pipe_multiplier: TAG_W must be at least 1");
    end

    logic                  v0_q, v0_d;
    logic                  m0_q, m0_d;
    logic signed [A_W-1:0] a0_q, a0_d;
    logic        [B_W-1:0] b0_q, b0_d;
`ifdef PIPE_MULT_TAG_EN
    logic [TAG_W-1:0]      t0_q, t0_d;
`endif

    logic                  v_s   [0:B_W];
    logic                  m_s   [0:B_W];
    logic signed [A_W-1:0] a_s   [0:B_W];
    logic        [B_W-1:0] b_s   [0:B_W];
    logic signed [P_W-1:0] acc_s [0:B_W];
`ifdef PIPE_MULT_TAG_EN
    logic [TAG_W-1:0]      t_s   [0:B_W];
`endif

    // Input capture: bubbles advance valid but leave the operands untouched.
    always_comb begin
        v0_d = v0_q;
        m0_d = m0_q;
        a0_d = a0_q;
        b0_d = b0_q;
`ifdef PIPE_MULT_TAG_EN
        t0_d = t0_q;
`endif
        if (ce) begin
            v0_d = in_valid;
        end
        if (ce && in_valid) begin
            m0_d = in_b_signed;
            a0_d = in_a;
            b0_d = in_b;
`ifdef PIPE_MULT_TAG_EN
            t0_d = in_tag;
`endif
        end
    end

    // Input register with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0_q <= 1'b0;
            m0_q <= 1'b0;
            a0_q <= '0;
            b0_q <= '0;
`ifdef PIPE_MULT_TAG_EN
            t0_q <= '0;
`endif
        end else begin
            v0_q <= v0_d;
            m0_q <= m0_d;
            a0_q <= a0_d;
            b0_q <= b0_d;
`ifdef PIPE_MULT_TAG_EN
            t0_q <= t0_d;
`endif
        end
    end

    assign v_s[0]   = v0_q;
    assign m_s[0]   = m0_q;
    assign a_s[0]   = a0_q;
    assign b_s[0]   = b0_q;
    assign acc_s[0] = '0;
`ifdef PIPE_MULT_TAG_EN
    assign t_s[0]   = t0_q;
`endif

    for (genvar k = 1; k < LAT; k++) begin : g_stage
        mult_stage #(
            .A_W (A_W),
            .B_W (B_W),
            .K   (k)
`ifdef PIPE_MULT_TAG_EN
            ,
            .TAG_W (TAG_W)
`endif
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .ce        (ce),
            .in_valid  (v_s[k-1]),
            .in_mode   (m_s[k-1]),
            .in_a      (a_s[k-1]),
            .in_b      (b_s[k-1]),
            .in_acc    (acc_s[k-1]),
            .out_valid (v_s[k]),
            .out_mode  (m_s[k]),
            .out_a     (a_s[k]),
            .out_b     (b_s[k]),
            .out_acc   (acc_s[k])
`ifdef PIPE_MULT_TAG_EN
            ,
            .in_tag    (t_s[k-1]),
            .out_tag   (t_s[k])
`endif
        );
    end

    assign out_valid = v_s[B_W];
    assign out_p     = acc_s[B_W];
`ifdef PIPE_MULT_TAG_EN
    assign out_tag   = t_s[B_W];
`endif

endmodule

// File: tb/tb_pipe_multiplier.sv
// tb_pipe_multiplier: directed table, corner sequences and randomized
// traffic checked against an enabled-edge scoreboard model.
module tb_pipe_multiplier;

    localparam int A_W   = 11;
    localparam int B_W   = 8;
    localparam int TAG_W = 4;
    localparam int P_W   = A_W + B_W;
    localparam int LAT   = B_W + 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  ce;
    logic                  in_valid;
    logic signed [A_W-1:0] in_a;
    logic        [B_W-1:0] in_b;
    logic                  in_b_signed;
    logic                  out_valid;
    logic signed [P_W-1:0] out_p;
`ifdef PIPE_MULT_TAG_EN
    logic [TAG_W-1:0]      in_tag;
    logic [TAG_W-1:0]      out_tag;
`endif

    always #5 clk = ~clk;

    pipe_multiplier #(
        .A_W   (A_W),
        .B_W   (B_W),
        .TAG_W (TAG_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .in_valid    (in_valid),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_b_signed (in_b_signed),
        .out_valid   (out_valid),
        .out_p       (out_p)
`ifdef PIPE_MULT_TAG_EN
        ,
        .in_tag      (in_tag),
        .out_tag     (out_tag)
`endif
    );

    typedef struct {
        logic signed [A_W-1:0] a;
        logic        [B_W-1:0] b;
        logic                  m;
        logic signed [P_W-1:0] p;
    } vec_t;

    typedef struct {
        int                    due;
        logic signed [P_W-1:0] p;
        logic [TAG_W-1:0]      t;
    } exp_t;

    exp_t                  sb[$];
    int                    ecount;
    logic                  exp_valid;
    logic signed [P_W-1:0] exp_p;
    logic [TAG_W-1:0]      exp_tag;
    int                    n_cmp;
    int                    n_bad;

    function automatic logic signed [P_W-1:0] golden(
        input logic signed [A_W-1:0] a,
        input logic        [B_W-1:0] b,
        input logic                  m
    );
        longint av;
        longint bv;
        av = longint'(a);
        bv = m ? longint'($signed(b)) : longint'(b);
        return P_W'(av * bv);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock: drive, update model on enabled edges, compare #1 after edge.
    task automatic step(
        input logic                  c,
        input logic                  v,
        input logic                  m,
        input logic signed [A_W-1:0] a,
        input logic        [B_W-1:0] b
    );
        logic [TAG_W-1:0] t;
        t           = TAG_W'($urandom);
        ce          = c;
        in_valid    = v;
        in_b_signed = m;
        in_a        = a;
        in_b        = b;
`ifdef PIPE_MULT_TAG_EN
        in_tag      = t;
`endif
        if (c && v) begin
            sb.push_back('{ecount + LAT, golden(a, b, m), t});
        end
        @(posedge clk);
        #1;
        if (c) begin
            ecount++;
            if (sb.size() > 0 && sb[0].due == ecount) begin
                exp_valid = 1'b1;
                exp_p     = sb[0].p;
                exp_tag   = sb[0].t;
                void'(sb.pop_front());
            end else begin
                exp_valid = 1'b0;
            end
        end
        chk("out_valid", 64'(out_valid), 64'(exp_valid));
        chk("out_p", 64'(out_p), 64'(exp_p));
`ifdef PIPE_MULT_TAG_EN
        if (exp_valid) begin
            chk("out_tag", 64'(out_tag), 64'(exp_tag));
        end
`endif
    endtask

    task automatic bubble();
        step(1'b1, 1'b0, 1'b0, '0, '0);
    endtask

    vec_t tbl[9];

    initial begin
        int first;
        int cnt;

        n_cmp     = 0;
        n_bad     = 0;
        ecount    = 0;
        exp_valid = 1'b0;
        exp_p     = '0;
        exp_tag   = '0;

        tbl[0] = '{A_W'(-1024), 8'h80, 1'b1, P_W'(131072)};
        tbl[1] = '{A_W'(5),     8'hFF, 1'b0, P_W'(1275)};
        tbl[2] = '{A_W'(5),     8'hFF, 1'b1, P_W'(-5)};
        tbl[3] = '{A_W'(1023),  8'hFF, 1'b0, P_W'(260865)};
        tbl[4] = '{A_W'(-1024), 8'hFF, 1'b0, P_W'(-261120)};
        tbl[5] = '{A_W'(1023),  8'h80, 1'b1, P_W'(-130944)};
        tbl[6] = '{A_W'(0),     8'hFF, 1'b1, P_W'(0)};
        tbl[7] = '{A_W'(-1),    8'h01, 1'b1, P_W'(-1)};
        tbl[8] = '{A_W'(-1024), 8'h7F, 1'b1, P_W'(-130048)};

        // Reset holds everything at zero even with ce and in_valid active.
        rst         = 1'b1;
        ce          = 1'b1;
        in_valid    = 1'b1;
        in_a        = A_W'(77);
        in_b        = 8'h33;
        in_b_signed = 1'b1;
`ifdef PIPE_MULT_TAG_EN
        in_tag      = '1;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_p", 64'(out_p), 64'(0));
        rst      = 1'b0;
        in_valid = 1'b0;

        // Isolated samples: result exactly LAT cycles later, then held.
        foreach (tbl[i]) begin
            step(1'b1, 1'b1, tbl[i].m, tbl[i].a, tbl[i].b);
            repeat (LAT - 1) bubble();
            chk("tbl_valid", 64'(out_valid), 64'(1));
            chk("tbl_p", 64'(out_p), 64'(tbl[i].p));
            bubble();
            chk("tbl_hold", 64'(out_p), 64'(tbl[i].p));
        end

        // Same operand bits, mixed modes back-to-back.
        step(1'b1, 1'b1, 1'b0, A_W'(5), 8'hFF);
        step(1'b1, 1'b1, 1'b1, A_W'(5), 8'hFF);
        repeat (LAT - 2) bubble();
        chk("b2b_first", 64'(out_p), 64'(P_W'(1275)));
        bubble();
        chk("b2b_second_v", 64'(out_valid), 64'(1));
        chk("b2b_second", 64'(out_p), 64'(P_W'(-5)));
        bubble();
        chk("b2b_after", 64'(out_valid), 64'(0));

        // Four stalled cycles mid-flight push the result to cycle 13.
        step(1'b1, 1'b1, 1'b0, A_W'(3), 8'd7);
        repeat (3) bubble();
        repeat (4) step(1'b0, 1'b1, 1'b1, A_W'(-9), 8'h55);
        first = 0;
        cnt   = 0;
        for (int s = 9; s <= 20; s++) begin
            bubble();
            if (out_valid) begin
                cnt++;
                if (first == 0) first = s;
                chk("stall_p", 64'(out_p), 64'(P_W'(21)));
            end
        end
        chk("stall_at", 64'(first), 64'(13));
        chk("stall_cnt", 64'(cnt), 64'(1));

        // Reset mid-flight discards everything in the pipe.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1, A_W'(i + 1), B_W'(i + 2));
        end
        rst = 1'b1;
        sb.delete();
        exp_valid = 1'b0;
        exp_p     = '0;
        #1;
        chk("rst_mid_valid", 64'(out_valid), 64'(0));
        chk("rst_mid_p", 64'(out_p), 64'(0));
        ce       = 1'b1;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_hold_valid", 64'(out_valid), 64'(0));
        step(1'b1, 1'b1, 1'b1, A_W'(-7), 8'd9);
        first = (out_valid === 1'b1) ? 1 : 0;
        for (int s = 2; s <= 14; s++) begin
            bubble();
            if (out_valid && first == 0) first = s;
        end
        chk("rst_first_at", 64'(first), 64'(LAT));
        chk("rst_first_p", 64'(out_p), 64'(P_W'(-63)));

        // Randomized traffic with stalls and bubbles.
        repeat (4000) begin
            step(($urandom_range(0, 4) != 0), ($urandom_range(0, 9) < 7),
                 1'($urandom), A_W'($urandom), B_W'($urandom));
        end
        repeat (LAT + 2) bubble();
        chk("drained", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
